// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing sequencer: opcodes, ALU function
// encodings, sequencer states and small decode helpers.
package alu_share_pkg;

    localparam int WIDTH = 16;

    // Instruction opcodes understood by the sequencer
    localparam logic [4:0] OP_JR     = 5'b00101;
    localparam logic [4:0] OP_ADDI   = 5'b01000;
    localparam logic [4:0] OP_SUBI   = 5'b01001;
    localparam logic [4:0] OP_XORI   = 5'b01010;
    localparam logic [4:0] OP_ANDNI  = 5'b01011;
    localparam logic [4:0] OP_ST     = 5'b10000;
    localparam logic [4:0] OP_LD     = 5'b10001;
    localparam logic [4:0] OP_SLBI   = 5'b10010;
    localparam logic [4:0] OP_STU    = 5'b10011;
    localparam logic [4:0] OP_ROLI   = 5'b10100;
    localparam logic [4:0] OP_SLLI   = 5'b10101;
    localparam logic [4:0] OP_RORI   = 5'b10110;
    localparam logic [4:0] OP_SRLI   = 5'b10111;
    localparam logic [4:0] OP_LBI    = 5'b11000;
    localparam logic [4:0] OP_BTR    = 5'b11001;
    localparam logic [4:0] OP_SHIFTR = 5'b11010;
    localparam logic [4:0] OP_ARITHR = 5'b11011;
    localparam logic [4:0] OP_SEQ    = 5'b11100;
    localparam logic [4:0] OP_SLT    = 5'b11101;
    localparam logic [4:0] OP_SLE    = 5'b11110;
    localparam logic [4:0] OP_SCO    = 5'b11111;

    // ALU function select encodings
    localparam logic [3:0] ALU_ROL  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_ROR  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_ANDN = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC1   = 3'd1,
        ST_EXEC2   = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_RESP    = 3'd4
    } seqState_e;

    function automatic logic [WIDTH-1:0] bitReverse(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] rev;
        rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = value[WIDTH-1-i];
        end
        return rev;
    endfunction

    // Shift/rotate selector shared by immediate and register forms
    function automatic logic [3:0] shiftFunc(input logic [1:0] sel);
        case (sel)
            2'b00:   return ALU_ROL;
            2'b01:   return ALU_SLL;
            2'b10:   return ALU_ROR;
            default: return ALU_SRL;
        endcase
    endfunction

    // Register-form arithmetic selector
    function automatic logic [3:0] arithFunc(input logic [1:0] sel);
        case (sel)
            2'b00:   return ALU_ADD;
            2'b01:   return ALU_SUB;
            2'b10:   return ALU_XOR;
            default: return ALU_ANDN;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_seq_if.sv
// Request, response and ALU-control bundle for the ALU sharing sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface alu_share_seq_if;
    import alu_share_pkg::*;

    logic             r0_valid, r1_valid;
    logic             r0_ready, r1_ready;
    logic [4:0]       r0_op, r1_op;
    logic [1:0]       r0_func, r1_func;
    logic [WIDTH-1:0] r0_a, r1_a, r0_b, r1_b;

    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0] rsp_data;

    logic [3:0]       alu_op;
    logic             alu_invb, alu_cin;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             alu_cout, alu_ofl, alu_zero;

    modport slave (
        input  r0_valid, r1_valid, r0_op, r1_op, r0_func, r1_func,
        input  r0_a, r1_a, r0_b, r1_b, rsp_ready,
        input  alu_out, alu_cout, alu_ofl, alu_zero,
        output r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data,
        output alu_op, alu_invb, alu_cin, alu_a, alu_b
    );

    modport master (
        output r0_valid, r1_valid, r0_op, r1_op, r0_func, r1_func,
        output r0_a, r1_a, r0_b, r1_b, rsp_ready,
        output alu_out, alu_cout, alu_ofl, alu_zero,
        input  r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data,
        input  alu_op, alu_invb, alu_cin, alu_a, alu_b
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// last time is granted; the last-grant record moves only on an advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic lastGrantR;   // 1: requester 1 was granted last

    // One-hot grant from current requests and the last-grant record
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = lastGrantR ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember who was granted, only when a grant is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrantR <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            lastGrantR <= grant[1];
        end else begin
            lastGrantR <= lastGrantR;
        end
    end

endmodule

// File: rtl/alu_share_seq.sv
// Sequencer for the shared execute ALU: arbitrates two requesters, drives
// the combinational ALU over one or two passes, resolves compare/carry/
// bit-reverse/SLBI results locally and returns a tagged response.
module alu_share_seq
    import alu_share_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_share_seq_if.slave bus
);

    seqState_e        stateR, nextStateS;
    logic [4:0]       opR;
    logic [1:0]       funcR;
    logic [WIDTH-1:0] aR, bR, latchR;
    logic             idR, signR, oflR, zeroR, coutR;
    logic             rspValidR, rspIdR;
    logic [WIDTH-1:0] rspDataR, rspNextS;
    logic             loadRspS, ltS, flagS;
    logic [1:0]       grantS;
    logic             acceptS;
    logic [3:0]       execOpS;
    logic             knownOpS, isCompareS;

    assign acceptS      = (stateR == ST_IDLE) && (bus.r0_valid || bus.r1_valid) && !rst;
    assign bus.r0_ready = acceptS && grantS[0];
    assign bus.r1_ready = acceptS && grantS[1];
    assign bus.rsp_valid = rspValidR;
    assign bus.rsp_data  = rspDataR;
    assign bus.rsp_id    = rspIdR;

    rr_arb2 arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({bus.r1_valid, bus.r0_valid}),
        .advance (acceptS),
        .grant   (grantS)
    );

    // Decode the captured opcode into the first-pass ALU function
    always_comb begin
        execOpS    = ALU_ADD;
        knownOpS   = 1'b1;
        isCompareS = 1'b0;
        case (opR)
            OP_ADDI, OP_ST, OP_LD, OP_STU, OP_JR, OP_LBI, OP_BTR: execOpS = ALU_ADD;
            OP_SUBI:  execOpS = ALU_SUB;
            OP_XORI:  execOpS = ALU_XOR;
            OP_ANDNI: execOpS = ALU_ANDN;
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: execOpS = shiftFunc(opR[1:0]);
            OP_SHIFTR: execOpS = shiftFunc(funcR);
            OP_ARITHR: execOpS = arithFunc(funcR);
            OP_SEQ, OP_SLT, OP_SLE: begin
                execOpS    = ALU_SUB;
                isCompareS = 1'b1;
            end
            OP_SCO: begin
                execOpS    = ALU_ADD;
                isCompareS = 1'b1;
            end
            OP_SLBI: execOpS = ALU_SLL;
            default: begin
                execOpS  = ALU_ADD;
                knownOpS = 1'b0;
            end
        endcase
    end

    // ALU control: active only in the execute passes, quiet ADD of zeros otherwise
    always_comb begin
        bus.alu_op   = ALU_ADD;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_invb = 1'b0;
        bus.alu_cin  = 1'b0;
        if (stateR == ST_EXEC1) begin
            bus.alu_op = execOpS;
            bus.alu_a  = (opR == OP_LBI) ? '0 : aR;
            if (opR == OP_BTR) begin
                bus.alu_b = '0;
            end else if (opR == OP_SLBI) begin
                bus.alu_b = {{(WIDTH-4){1'b0}}, 4'd8};
            end else begin
                bus.alu_b = bR;
            end
        end else if (stateR == ST_EXEC2) begin
            bus.alu_op = ALU_XOR;
            bus.alu_a  = latchR;
            bus.alu_b  = {{(WIDTH-8){1'b0}}, bR[7:0]};
        end else begin
            bus.alu_op = ALU_ADD;
        end
    end

    // Next state and the value loaded into the response register
    always_comb begin
        nextStateS = stateR;
        rspNextS   = '0;
        loadRspS   = 1'b0;
        ltS        = signR ^ oflR;
        case (opR)
            OP_SEQ:  flagS = zeroR;
            OP_SLT:  flagS = ltS;
            OP_SLE:  flagS = zeroR | ltS;
            OP_SCO:  flagS = coutR;
            default: flagS = 1'b0;
        endcase
        case (stateR)
            ST_IDLE: begin
                if (acceptS) begin
                    nextStateS = ST_EXEC1;
                end else begin
                    nextStateS = ST_IDLE;
                end
            end
            ST_EXEC1: begin
                if (opR == OP_SLBI) begin
                    nextStateS = ST_EXEC2;
                end else if (isCompareS) begin
                    nextStateS = ST_RESOLVE;
                end else begin
                    nextStateS = ST_RESP;
                    loadRspS   = 1'b1;
                    if (!knownOpS) begin
                        rspNextS = '0;
                    end else if (opR == OP_BTR) begin
                        rspNextS = bitReverse(bus.alu_out);
                    end else begin
                        rspNextS = bus.alu_out;
                    end
                end
            end
            ST_EXEC2: begin
                nextStateS = ST_RESP;
                loadRspS   = 1'b1;
                rspNextS   = bus.alu_out;
            end
            ST_RESOLVE: begin
                nextStateS = ST_RESP;
                loadRspS   = 1'b1;
                rspNextS   = {{(WIDTH-1){1'b0}}, flagS};
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    nextStateS = ST_IDLE;
                end else begin
                    nextStateS = ST_RESP;
                end
            end
            default: nextStateS = ST_IDLE;
        endcase
    end

    // State, request capture, first-pass latches and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR    <= ST_IDLE;
            opR       <= 5'd0;
            funcR     <= 2'd0;
            aR        <= '0;
            bR        <= '0;
            idR       <= 1'b0;
            latchR    <= '0;
            signR     <= 1'b0;
            oflR      <= 1'b0;
            zeroR     <= 1'b0;
            coutR     <= 1'b0;
            rspValidR <= 1'b0;
            rspDataR  <= '0;
            rspIdR    <= 1'b0;
        end else begin
            stateR    <= nextStateS;
            rspValidR <= (nextStateS == ST_RESP);
            if (acceptS) begin
                if (grantS[1]) begin
                    opR   <= bus.r1_op;
                    funcR <= bus.r1_func;
                    aR    <= bus.r1_a;
                    bR    <= bus.r1_b;
                    idR   <= 1'b1;
                end else begin
                    opR   <= bus.r0_op;
                    funcR <= bus.r0_func;
                    aR    <= bus.r0_a;
                    bR    <= bus.r0_b;
                    idR   <= 1'b0;
                end
            end
            if (stateR == ST_EXEC1) begin
                latchR <= bus.alu_out;
                signR  <= bus.alu_out[WIDTH-1];
                oflR   <= bus.alu_ofl;
                zeroR  <= bus.alu_zero;
                coutR  <= bus.alu_cout;
            end
            if (loadRspS) begin
                rspDataR <= rspNextS;
                rspIdR   <= idR;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_seq.sv
// Self-checking bench for alu_share_seq: directed steps plus randomized
// operations checked against an instruction-level reference model, with a
// behavioural ALU attached to the sequencer's ALU port.
module tb_alu_share_seq;
    import alu_share_pkg::*;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;
    int   refLast;

    alu_share_seq_if bus ();

    alu_share_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural combinational ALU
    logic [15:0] aluBEff;
    logic [16:0] aluSum;
    logic [31:0] aluRot;
    always_comb begin
        aluBEff      = bus.alu_invb ? ~bus.alu_b : bus.alu_b;
        aluSum       = {1'b0, bus.alu_a} + {1'b0, aluBEff} + {16'd0, bus.alu_cin};
        aluRot       = 32'd0;
        bus.alu_out  = aluSum[15:0];
        bus.alu_cout = aluSum[16];
        bus.alu_ofl  = (bus.alu_a[15] == aluBEff[15]) && (aluSum[15] != bus.alu_a[15]);
        case (bus.alu_op)
            ALU_ROL: begin
                aluRot = {bus.alu_a, bus.alu_a} << bus.alu_b[3:0];
                bus.alu_out = aluRot[31:16];
            end
            ALU_SLL: bus.alu_out = bus.alu_a << bus.alu_b[3:0];
            ALU_ROR: begin
                aluRot = {bus.alu_a, bus.alu_a} >> bus.alu_b[3:0];
                bus.alu_out = aluRot[15:0];
            end
            ALU_SRL:  bus.alu_out = bus.alu_a >> bus.alu_b[3:0];
            ALU_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
            ALU_ANDN: bus.alu_out = bus.alu_a & ~bus.alu_b;
            ALU_SUB: begin
                aluSum       = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
                bus.alu_out  = aluSum[15:0];
                bus.alu_cout = aluSum[16];
                bus.alu_ofl  = (bus.alu_a[15] != bus.alu_b[15]) && (aluSum[15] != bus.alu_a[15]);
            end
            default: ;
        endcase
        bus.alu_zero = (bus.alu_out == 16'd0);
    end

    function automatic logic [15:0] shiftRef(input logic [1:0] kind, input logic [15:0] a,
                                             input logic [3:0] amt);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(amt)) begin
                case (kind)
                    2'b00:   r = {r[14:0], r[15]};
                    2'b01:   r = {r[14:0], 1'b0};
                    2'b10:   r = {r[0], r[15:1]};
                    default: r = {1'b0, r[15:1]};
                endcase
            end
        end
        return r;
    endfunction

    // Instruction-level result of one request
    function automatic logic [15:0] refModel(input logic [4:0] op, input logic [1:0] fn,
                                             input logic [15:0] a, input logic [15:0] b);
        logic [16:0] wide;
        logic [15:0] rev;
        wide = {1'b0, a} + {1'b0, b};
        for (int i = 0; i < 16; i++) rev[i] = a[15-i];
        case (op)
            OP_ADDI, OP_ST, OP_LD, OP_STU, OP_JR: return a + b;
            OP_SUBI:  return a - b;
            OP_XORI:  return a ^ b;
            OP_ANDNI: return a & ~b;
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: return shiftRef(op[1:0], a, b[3:0]);
            OP_SHIFTR: return shiftRef(fn, a, b[3:0]);
            OP_ARITHR: begin
                case (fn)
                    2'b00:   return a + b;
                    2'b01:   return a - b;
                    2'b10:   return a ^ b;
                    default: return a & ~b;
                endcase
            end
            OP_LBI:  return b;
            OP_BTR:  return rev;
            OP_SEQ:  return (a == b) ? 16'd1 : 16'd0;
            OP_SLT:  return ($signed(a) <  $signed(b)) ? 16'd1 : 16'd0;
            OP_SLE:  return ($signed(a) <= $signed(b)) ? 16'd1 : 16'd0;
            OP_SCO:  return {15'd0, wide[16]};
            OP_SLBI: return {a[7:0], 8'h00} ^ {8'h00, b[7:0]};
            default: return 16'd0;
        endcase
    endfunction

    function automatic int latOf(input logic [4:0] op);
        if (op == OP_SLBI || op == OP_SEQ || op == OP_SLT || op == OP_SLE || op == OP_SCO) return 3;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int id, input logic v, input logic [4:0] op, input logic [1:0] fn,
                          input logic [15:0] a, input logic [15:0] b);
        if (id == 0) begin
            bus.r0_valid = v; bus.r0_op = op; bus.r0_func = fn; bus.r0_a = a; bus.r0_b = b;
        end else begin
            bus.r1_valid = v; bus.r1_op = op; bus.r1_func = fn; bus.r1_a = a; bus.r1_b = b;
        end
    endtask

    // Wait (bounded) for a ready; returns in the accepting cycle, before its edge
    task automatic waitGrant(input string tag, output int gid);
        int n;
        n = 0;
        #1;
        while (!bus.r0_ready && !bus.r1_ready && n < 30) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_grant_seen"}, (n < 30) ? 32'd1 : 32'd0, 32'd1);
        check({tag, "_ready_onehot"}, {31'd0, bus.r0_ready & bus.r1_ready}, 32'd0);
        gid = bus.r1_ready ? 1 : 0;
    endtask

    // Called just after the accept edge; counts cycles until rsp_valid
    task automatic waitRsp(input string tag, input int expId, input logic [15:0] expData,
                           input int expLat);
        int lat;
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, expLat);
        check({tag, "_data"}, bus.rsp_data, expData);
        check({tag, "_id"}, {31'd0, bus.rsp_id}, expId);
        check({tag, "_no_ready_in_rsp"}, {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
    endtask

    task automatic runOne(input string tag, input int id, input logic [4:0] op,
                          input logic [1:0] fn, input logic [15:0] a, input logic [15:0] b);
        int gid;
        setReq(id, 1'b1, op, fn, a, b);
        waitGrant(tag, gid);
        check({tag, "_gid"}, gid, id);
        refLast = gid;
        tick();
        setReq(id, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        waitRsp(tag, id, refModel(op, fn, a, b), latOf(op));
    endtask

    logic [4:0]  opPool [22];
    logic [4:0]  rOp;
    logic [1:0]  rFn;
    logic [15:0] rA, rB, expStall;
    int          rId, gid, expGid;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        refLast     = 1;
        opPool = '{OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI,
                   OP_ST, OP_LD, OP_SLBI, OP_STU, OP_LBI, OP_BTR, OP_SHIFTR, OP_ARITHR,
                   OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_JR, 5'b00000};

        // Reset with both requesters asserting
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        setReq(0, 1'b1, OP_ADDI, 2'd0, 16'd1, 16'd1);
        setReq(1, 1'b1, OP_ADDI, 2'd0, 16'd1, 16'd1);
        tick();
        tick();
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_data", bus.rsp_data, 32'd0);
        check("reset_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        check("reset_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        check("reset_alu_op", bus.alu_op, ALU_ADD);
        check("reset_alu_a", bus.alu_a, 32'd0);
        setReq(0, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        setReq(1, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        rst = 1'b0;
        tick();

        // Both held valid: grants alternate starting with r0
        setReq(0, 1'b1, OP_ARITHR, 2'b00, 16'h0001, 16'h0002);
        setReq(1, 1'b1, OP_ARITHR, 2'b00, 16'h0100, 16'h0200);
        for (int k = 0; k < 4; k++) begin
            waitGrant("alt", gid);
            expGid = (refLast == 1) ? 0 : 1;
            check("alt_grant", gid, expGid);
            refLast = gid;
            tick();
            waitRsp("alt", gid, (gid == 1) ? 16'h0300 : 16'h0003, 2);
        end
        setReq(0, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        setReq(1, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);

        // Directed operations
        runOne("add_ovf", 0, OP_ADDI, 2'd0, 16'h7FFF, 16'h0001);
        runOne("slt", 1, OP_SLT, 2'd0, 16'h8000, 16'h0001);
        runOne("sle_eq", 1, OP_SLE, 2'd0, 16'h1234, 16'h1234);
        runOne("seq_ne", 0, OP_SEQ, 2'd0, 16'h0005, 16'h0006);
        runOne("btr", 0, OP_BTR, 2'd0, 16'h0001, 16'h0000);
        runOne("sco", 1, OP_SCO, 2'd0, 16'hFFFF, 16'h0001);
        runOne("lbi", 0, OP_LBI, 2'd0, 16'h5555, 16'hFF80);
        runOne("unknown", 1, 5'b00001, 2'd0, 16'h1111, 16'h2222);

        // SLBI: SLL pass then XOR pass
        setReq(0, 1'b1, OP_SLBI, 2'd0, 16'h00AB, 16'h00CD);
        waitGrant("slbi", gid);
        check("slbi_gid", gid, 0);
        refLast = gid;
        tick();
        setReq(0, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        check("slbi_exec1_op", bus.alu_op, ALU_SLL);
        check("slbi_exec1_b", bus.alu_b, 32'd8);
        tick();
        check("slbi_exec2_op", bus.alu_op, ALU_XOR);
        check("slbi_exec2_b", bus.alu_b, 32'h00CD);
        tick();
        check("slbi_valid_t3", {31'd0, bus.rsp_valid}, 32'd1);
        check("slbi_data", bus.rsp_data, 32'hABCD);
        check("idle_alu_op", bus.alu_op, ALU_ADD);
        check("idle_alu_b", bus.alu_b, 32'd0);

        // Stalled response: data/id stable, no ready while held
        tick();
        bus.rsp_ready = 1'b0;
        setReq(1, 1'b1, OP_ARITHR, 2'b10, 16'hF0F0, 16'h3C3C);
        expStall = refModel(OP_ARITHR, 2'b10, 16'hF0F0, 16'h3C3C);
        waitGrant("stall", gid);
        check("stall_gid", gid, 1);
        refLast = gid;
        tick();
        setReq(0, 1'b1, OP_ADDI, 2'd0, 16'd9, 16'd9);
        waitRsp("stall", 1, expStall, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_data", bus.rsp_data, expStall);
            check("stall_id", {31'd0, bus.rsp_id}, 32'd1);
            check("stall_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        end
        setReq(0, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        setReq(1, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        bus.rsp_ready = 1'b1;
        tick();
        check("stall_release", {31'd0, bus.rsp_valid}, 32'd0);

        // Randomized single-requester operations
        for (int k = 0; k < 40; k++) begin
            rOp = opPool[$urandom_range(0, 21)];
            rFn = 2'($urandom_range(0, 3));
            if (rOp[4:2] == 3'b101) rFn = rOp[1:0];
            case ($urandom_range(0, 4))
                0:       rA = 16'h8000;
                1:       rA = 16'h7FFF;
                2:       rA = 16'hFFFF;
                default: rA = 16'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) rB = rA;
            else rB = 16'($urandom);
            rId = $urandom_range(0, 1);
            runOne("rand", rId, rOp, rFn, rA, rB);
        end

        // Reset in EXEC1 drops the operation and restores the tie pointer
        tick();
        setReq(0, 1'b1, OP_ADDI, 2'd0, 16'h0003, 16'h0004);
        waitGrant("rstmid", gid);
        check("rstmid_gid", gid, 0);
        refLast = gid;
        tick();
        setReq(0, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        check("rstmid_in_exec1", bus.alu_a, 32'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        refLast = 1;
        check("rstmid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rstmid_alu_a", bus.alu_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rstmid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        setReq(0, 1'b1, OP_XORI, 2'd0, 16'h00FF, 16'h0F0F);
        setReq(1, 1'b1, OP_XORI, 2'd0, 16'h1234, 16'h0000);
        waitGrant("rsttie", gid);
        expGid = (refLast == 1) ? 0 : 1;
        check("rsttie_grant", gid, expGid);
        refLast = gid;
        tick();
        setReq(0, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        setReq(1, 1'b0, 5'd0, 2'd0, 16'd0, 16'd0);
        waitRsp("rsttie", expGid, (expGid == 0) ? 16'h0FF0 : 16'h1234, 2);
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
